decode_regfile_mp: RTL and testbench

//  Parametrised decode-stage register file: NRD synchronous read ports behind one output register stage,
//  one writeback port with optional write-to-read bypass, and a pending-write scoreboard that stalls

---
 rtl/decode_regfile_mp_if.sv | 35 +++
 rtl/decode_regfile_mp.sv | 96 +++++++++
 tb/tb_decode_regfile_mp.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_regfile_mp_if.sv
// Decode/execute/writeback handshake bundle for the decode-stage register file.
// Master side is the surrounding pipeline, slave side is the register file.
interface decode_regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                dec_valid;
    logic                dec_ready;
    logic [NRD*AW-1:0]   rs_addr;
    logic                dst_set;
    logic [AW-1:0]       dst_addr;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [NRD*XLEN-1:0] rs_data;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                busy;

    modport master (
        output dec_valid, rs_addr, dst_set, dst_addr, flush,
        output out_ready, wr_en, wr_addr, wr_data,
        input  dec_ready, out_valid, rs_data, busy
    );

    modport slave (
        input  dec_valid, rs_addr, dst_set, dst_addr, flush,
        input  out_ready, wr_en, wr_addr, wr_data,
        output dec_ready, out_valid, rs_data, busy
    );
endinterface

// File: rtl/decode_regfile_mp.sv
// Decode-stage register file: NRD registered read ports, writeback bypass,
// and a pending-write scoreboard that stalls decode on load-use hazards.
module decode_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int SCORE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    decode_regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     mem [NREGS];
    logic [NREGS-1:0]    pend;
    logic [NREGS-1:0]    pend_n;
    logic [AW-1:0]       rs [NRD];
    logic [NRD-1:0]      wr_hit;
    logic [NRD-1:0]      hz;
    logic [NRD*XLEN-1:0] data_n;
    logic [NRD*XLEN-1:0] data_q;
    logic                out_valid_q;
    logic                hazard;
    logic                ready;
    logic                accept;

    always_comb begin
        hz     = '0;
        wr_hit = '0;
        data_n = '0;
        for (int i = 0; i < NRD; i++) begin
            rs[i]     = bus.rs_addr[i*AW +: AW];
            wr_hit[i] = bus.wr_en && (bus.wr_addr == rs[i])
                        && (rs[i] != '0);
            hz[i] = ((SCORE != 0) && pend[rs[i]] && !wr_hit[i])
                    || ((BYPASS == 0) && wr_hit[i]);
            if ((BYPASS != 0) && wr_hit[i])
                data_n[i*XLEN +: XLEN] = bus.wr_data;
            else if (rs[i] != '0)
                data_n[i*XLEN +: XLEN] = mem[rs[i]];
        end
    end

    assign hazard = |hz;
    assign ready  = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign accept = bus.dec_valid && ready;

    // Set beats clear when the same index is marked and written back together.
    always_comb begin
        pend_n = pend;
        if (bus.wr_en)
            pend_n[bus.wr_addr] = 1'b0;
        if ((SCORE != 0) && accept && bus.dst_set && (bus.dst_addr != '0))
            pend_n[bus.dst_addr] = 1'b1;
        pend_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++)
                mem[r] <= '0;
        end else if (bus.wr_en && (bus.wr_addr != '0)) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pend <= '0;
        else
            pend <= pend_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
        end else begin
            if (bus.flush)
                out_valid_q <= 1'b0;
            else if (accept)
                out_valid_q <= 1'b1;
            else if (bus.out_ready)
                out_valid_q <= 1'b0;
            if (accept)
                data_q <= data_n;
        end
    end

    assign bus.dec_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.rs_data   = data_q;
    assign bus.busy      = |pend;
endmodule

// File: tb/tb_decode_regfile_mp.sv
// Bench for decode_regfile_mp: BYPASS=1 and BYPASS=0 instances share stimulus,
// each tracked by its own behavioural model; directed steps then random traffic.
module tb_decode_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                dec_valid;
    logic [NRD*AW-1:0]   rs_addr;
    logic                dst_set;
    logic [AW-1:0]       dst_addr;
    logic                flush;
    logic                out_ready;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;

    decode_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) ifa ();
    decode_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) ifb ();

    assign ifa.dec_valid = dec_valid;
    assign ifa.rs_addr   = rs_addr;
    assign ifa.dst_set   = dst_set;
    assign ifa.dst_addr  = dst_addr;
    assign ifa.flush     = flush;
    assign ifa.out_ready = out_ready;
    assign ifa.wr_en     = wr_en;
    assign ifa.wr_addr   = wr_addr;
    assign ifa.wr_data   = wr_data;
    assign ifb.dec_valid = dec_valid;
    assign ifb.rs_addr   = rs_addr;
    assign ifb.dst_set   = dst_set;
    assign ifb.dst_addr  = dst_addr;
    assign ifb.flush     = flush;
    assign ifb.out_ready = out_ready;
    assign ifb.wr_en     = wr_en;
    assign ifb.wr_addr   = wr_addr;
    assign ifb.wr_data   = wr_data;

    decode_regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .SCORE(1)
    ) u_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    decode_regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .SCORE(1)
    ) u_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    // Model state, index 0 = bypass instance, 1 = stalling instance
    logic [31:0] m_regs [2][32];
    bit          m_pend [2][32];
    bit          m_ov   [2];
    logic [63:0] m_data [2];
    int          n_vec;
    int          n_err;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic g_ready(int k);
        return (k == 0) ? ifa.dec_ready : ifb.dec_ready;
    endfunction
    function automatic logic g_ov(int k);
        return (k == 0) ? ifa.out_valid : ifb.out_valid;
    endfunction
    function automatic logic g_busy(int k);
        return (k == 0) ? ifa.busy : ifb.busy;
    endfunction
    function automatic logic [63:0] g_data(int k);
        return (k == 0) ? ifa.rs_data : ifb.rs_data;
    endfunction

    function automatic bit m_busy(int k);
        bit b = 0;
        for (int r = 0; r < 32; r++)
            b = b | m_pend[k][r];
        return b;
    endfunction

    function automatic bit m_ready(int k);
        logic [4:0] r;
        bit hit;
        if ((m_ov[k] && !out_ready) || flush)
            return 0;
        for (int i = 0; i < NRD; i++) begin
            r   = rs_addr[i*AW +: AW];
            hit = wr_en && (wr_addr == r) && (r != 0);
            if (m_pend[k][r] && !hit)
                return 0;
            if (k == 1 && hit)
                return 0;
        end
        return 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[k][r] = 0;
                m_pend[k][r] = 0;
            end
            m_ov[k]   = 0;
            m_data[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit acc;
        logic [4:0] r;
        for (int k = 0; k < 2; k++) begin
            acc = dec_valid && m_ready(k);
            if (acc) begin
                for (int i = 0; i < NRD; i++) begin
                    r = rs_addr[i*AW +: AW];
                    if (r == 0)
                        m_data[k][i*32 +: 32] = 0;
                    else if (k == 0 && wr_en && wr_addr == r)
                        m_data[k][i*32 +: 32] = wr_data;
                    else
                        m_data[k][i*32 +: 32] = m_regs[k][r];
                end
            end
            if (flush)
                m_ov[k] = 0;
            else if (acc)
                m_ov[k] = 1;
            else if (out_ready)
                m_ov[k] = 0;
            if (wr_en)
                m_pend[k][wr_addr] = 0;
            if (acc && dst_set && dst_addr != 0)
                m_pend[k][dst_addr] = 1;
            if (wr_en && wr_addr != 0)
                m_regs[k][wr_addr] = wr_data;
        end
    endtask

    task automatic cycle();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dec_ready%0d", k), 64'(g_ready(k)), 64'(m_ready(k)));
            chk($sformatf("busy%0d", k), 64'(g_busy(k)), 64'(m_busy(k)));
        end
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid%0d", k), 64'(g_ov(k)), 64'(m_ov[k]));
            chk($sformatf("rs_data%0d", k), g_data(k), m_data[k]);
        end
    endtask

    task automatic idle();
        dec_valid = 0;
        rs_addr   = '0;
        dst_set   = 0;
        dst_addr  = '0;
        flush     = 0;
        out_ready = 1;
        wr_en     = 0;
        wr_addr   = '0;
        wr_data   = '0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        model_reset();
        rst = 0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", 64'(g_ov(k)), 64'd0);
            chk("rst_busy", 64'(g_busy(k)), 64'd0);
            chk("rst_rs_data", g_data(k), 64'd0);
        end
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst_dec_ready", 64'(g_ready(0)), 64'd1);

        // reset mid-operation
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
        dec_valid = 1; dst_set = 1; dst_addr = 5;
        cycle();
        idle();
        cycle();
        chk("t1_busy_before", 64'(g_busy(0)), 64'd1);
        #2;
        rst = 0;
        #1;
        chk("t1_ov_reset", 64'(g_ov(0)), 64'd0);
        chk("t1_busy_reset", 64'(g_busy(0)), 64'd0);
        model_reset();
        #1;
        rst = 1;
        dec_valid = 1; rs_addr = 10'd5;
        cycle();
        chk("t1_x5_zero", g_data(0), 64'd0);

        // x0 behaviour
        idle();
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
        cycle();
        idle();
        dec_valid = 1; rs_addr = '0; dst_set = 1; dst_addr = 0;
        cycle();
        chk("t2_x0_read", 64'(g_data(0)), 64'd0);
        chk("t2_x0_busy", 64'(g_busy(0)), 64'd0);

        // write-to-read bypass vs stall
        idle();
        wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5_0001;
        dec_valid = 1; rs_addr = 10'd7;
        #1;
        chk("t3_ready_byp", 64'(g_ready(0)), 64'd1);
        chk("t3_ready_stall", 64'(g_ready(1)), 64'd0);
        cycle();
        chk("t3_byp_data", 64'(g_data(0)), 64'hA5A5_0001);
        wr_en = 0;
        cycle();
        chk("t3_stall_data", 64'(g_data(1)), 64'hA5A5_0001);

        // load-use hazard
        idle();
        dec_valid = 1; dst_set = 1; dst_addr = 3;
        cycle();
        idle();
        dec_valid = 1; rs_addr = {5'd3, 5'd0};
        cycle();
        cycle();
        chk("t4_stall", 64'(g_ready(0)), 64'd0);
        wr_en = 1; wr_addr = 3; wr_data = 32'h55;
        cycle();
        chk("t4_byp_data", 64'(g_data(0) >> 32), 64'h55);
        wr_en = 0;
        cycle();
        chk("t4_stall_data", 64'(g_data(1) >> 32), 64'h55);

        // backpressure hold
        idle();
        wr_en = 1; wr_addr = 10; wr_data = 32'h111;
        cycle();
        idle();
        dec_valid = 1; rs_addr = 10'd10;
        cycle();
        out_ready = 0;
        wr_en = 1; wr_addr = 10; wr_data = 32'h222;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t5_hold_a", g_data(0), 64'h111);
            chk("t5_hold_b", g_data(1), 64'h111);
            chk("t5_hold_ready", 64'(g_ready(0)), 64'd0);
        end
        out_ready = 1; wr_en = 0;
        cycle();
        chk("t5_resume", g_data(0), 64'h222);

        // flush keeps pend; set beats clear
        idle();
        dec_valid = 1; dst_set = 1; dst_addr = 12;
        cycle();
        idle();
        flush = 1; dec_valid = 1; out_ready = 0;
        cycle();
        chk("t6_flush_ov", 64'(g_ov(0)), 64'd0);
        chk("t6_flush_busy", 64'(g_busy(0)), 64'd1);
        idle();
        dec_valid = 1; dst_set = 1; dst_addr = 9;
        wr_en = 1; wr_addr = 9; wr_data = 32'h7;
        cycle();
        idle();
        wr_en = 1; wr_addr = 12; wr_data = 32'h12;
        cycle();
        chk("t6_pend9_busy", 64'(g_busy(0)), 64'd1);
        idle();
        dec_valid = 1; rs_addr = 10'd9;
        cycle();
        chk("t6_pend9_stall", 64'(g_ready(0)), 64'd0);
        wr_en = 1; wr_addr = 9; wr_data = 32'h99;
        cycle();
        idle();
        cycle();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            dec_valid = ($urandom_range(0, 3) != 0);
            rs_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            dst_set   = ($urandom_range(0, 3) == 0);
            dst_addr  = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_addr   = 5'($urandom_range(0, 7));
            wr_data   = $urandom;
            cycle();
        end
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
